vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator and pixel pipeline, the next generation of the fixed-mode VGA controller used by the camera/display path. It generates sync, blank and active-video timing for any mode given as generics, with a configurable pixel request lead so that frame buffer or SDRAM readers of any fixed latency stay aligned. It adds configurable sync polarity, a pixel clock enable, frame and line start strobes, and a fully delay-matched RGB/sync output stage. It sits between the frame buffer read port (host side) and the video DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical porch and sync (lines)
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level
- COLOR_W, 8, bits per colour channel
- REQ_LEAD, 2, ticks between oRequest and host data; legal range 1..16
- iCLK  in  1  clock
- iRST_N  in  1  reset; asynchronous, active-low
- iEn  in  1  pixel tick enable; all state advances only when high
- iRed/iGreen/iBlue  in  COLOR_W  host pixel data, sampled REQ_LEAD ticks after its request
- oRequest  out  1  host pixel fetch strobe for (oX, oY)
- oX  out  XBITS  requested column, 0..H_ACTIVE-1; XBITS = $clog2(H_TOTAL)
- oY  out  YBITS  requested row, 0..V_ACTIVE-1; YBITS = $clog2(V_TOTAL)
- oFrameStart  out  1  one-tick strobe together with the request for (0,0)
- oLineStart  out  1  one-tick strobe together with the request for (0,y) on every active line
- oVGA_R/G/B  out  COLOR_W  pixel output; 0 outside active video
- oVGA_HS/oVGA_VS  out  1  sync at configured polarity
- oVGA_BLANK_N  out  1  high during active video

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is defined the same way (default 525).
- hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments when hcnt wraps and counts 0..V_TOTAL-1 before wrapping. Both counters advance only on ticks where iEn=1.
- Horizontal regions, in order from hcnt=0: active [0,H_ACTIVE), then front porch, then sync, then back porch. Vertical regions use the same order.
- Request-time signals are combinational on the counters and registered once:
  - req_de = both counters in the active region.
  - hs_req and vs_req = counter in the sync region.
- oRequest equals req_de. When oRequest=1, oX=hcnt and oY=vcnt. When oRequest=0, oX=0 and oY=0.
- The delay line has depth REQ_LEAD. It carries {de, hs, vs} from request time to the output stage.
- Output register (on iEn):
  - oVGA_R/G/B = delayed de ? iRed/iGreen/iBlue : 0.
  - oVGA_BLANK_N = delayed de.
  - oVGA_HS = delayed hs ? HS_POL : ~HS_POL. oVGA_VS uses VS_POL the same way.
- iEn low: all registers, strobes and the delay line hold their values. Strobes are held, not re-pulsed; when iEn is used, a consumer qualifies strobes with iEn.
- Reset values:
  - Counters 0. oRequest, oFrameStart, oLineStart 0. oX, oY 0.
  - RGB 0. oVGA_BLANK_N 0.
  - oVGA_HS = ~HS_POL, oVGA_VS = ~VS_POL.
  - The delay line resets to the inactive value {0,0,0}.
- Reset mid-frame: the frame restarts at (0,0). The first oFrameStart appears on the first tick after release.

## Timing
- Request-to-pixel latency: request for (x,y) on tick n. Host data is valid on tick n+REQ_LEAD. Pixel appears on oVGA_* on tick n+REQ_LEAD+1.
- Sync and blank pass through the same delay, so they are exactly aligned with RGB.
- Per line, oRequest is high for exactly H_ACTIVE consecutive ticks on active lines and never high on vertical blanking lines.
- The first oVGA_BLANK_N rise after reset occurs REQ_LEAD+1 ticks after the first oRequest.
- HS width is H_SYNC ticks. VS width is V_SYNC·H_TOTAL ticks. VS edges coincide with HS-period boundaries at hcnt=0, delayed by REQ_LEAD+1.

## Structure
- Package vga_pkg holds:
  - the mode constants for the defaults (640x480@60 and 800x600@60 sets);
  - the function computing totals;
  - typedef vga_ctl_t = struct {de, hs, vs}.
- Sub-module vga_delay_line, parametrised by WIDTH and DEPTH, with enable and async reset. It is instantiated for vga_ctl_t.

## Test plan
- Reset with defaults: drive iRST_N low mid-line → all outputs at their reset values, HS=VS=1; after release, oFrameStart at tick 0 with oX=0, oY=0.
- Full frame with defaults and iEn=1:
  - 800 ticks per line, 525 lines;
  - 640×480 oRequest ticks per frame;
  - HS low for 96 ticks starting 656 ticks after line start;
  - VS low for 2 lines starting after line 490.
- Latency with REQ_LEAD=3 and host returning RGB={oX[7:0], oY[7:0], 8'hA5} three ticks after each request → every oVGA_R/G/B sample matches the pixel coordinates; no pixel shifts; RGB=0 while BLANK_N=0.
- Polarity with HS_POL=1, VS_POL=1, 800x600 mode → H_TOTAL=1056, V_TOTAL=628; syncs idle low and pulse high for 128 ticks and 4 lines respectively.
- iEn=1 on every second cycle → timing identical when counted in enabled ticks; outputs stable across disabled cycles.
- Wrap boundary: at hcnt=799, vcnt=524 → next tick hcnt=0, vcnt=0, oFrameStart=1; oLineStart pulses 480 times per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA mode constants, control bundle type and timing helper
package vga_pkg;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600@60 (40 MHz pixel clock)
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  // Control bits travelling alongside each pixel from request time to the pins
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vga_ctl_t;

  localparam vga_ctl_t VGA_CTL_IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0};

  // Total ticks (or lines) of one period made of active, porch and sync regions
  function automatic int vgaTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enable-gated shift register with asynchronous reset
module vga_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oData
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift one stage per enabled tick; every stage holds while iEn is low
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= RESET_VAL;
      end
    end else if (iEn) begin
      stages[0] <= iData;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign oData = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with delay-matched pixel output
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 8,
  parameter int   REQ_LEAD = 2,
  localparam int  H_TOTAL  = vgaTotal(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL  = vgaTotal(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  XBITS    = $clog2(H_TOTAL),
  localparam int  YBITS    = $clog2(V_TOTAL)
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEn,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oRequest,
  output logic [XBITS-1:0]   oX,
  output logic [YBITS-1:0]   oY,
  output logic               oFrameStart,
  output logic               oLineStart,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_N
);

  // Sync regions follow the active region and the front porch
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

  if (REQ_LEAD < 1 || REQ_LEAD > 16) begin : gBadLead
    $error("vga_timing_gen: REQ_LEAD must lie in 1..16");
  end

  logic [XBITS-1:0] hcnt;
  logic [YBITS-1:0] vcnt;
  int               hPos;
  int               vPos;
  logic             hActive;
  logic             vActive;
  logic             hLast;
  logic             vLast;
  vga_ctl_t         reqCtl;
  vga_ctl_t         reqCtlQ;
  vga_ctl_t         dlyCtl;

  // Region decode works on widened counters so a sync region ending at the
  // period boundary never aliases when H_TOTAL/V_TOTAL is a power of two
  assign hPos    = int'(hcnt);
  assign vPos    = int'(vcnt);
  assign hActive = hPos < H_ACTIVE;
  assign vActive = vPos < V_ACTIVE;
  assign hLast   = hPos == H_TOTAL - 1;
  assign vLast   = vPos == V_TOTAL - 1;

  assign reqCtl.de = hActive && vActive;
  assign reqCtl.hs = (hPos >= H_SYNC_BEG) && (hPos < H_SYNC_END);
  assign reqCtl.vs = (vPos >= V_SYNC_BEG) && (vPos < V_SYNC_END);

  // Raster position: hcnt wraps every line, vcnt advances on each hcnt wrap
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (iEn) begin
      if (hLast) begin
        hcnt <= '0;
        vcnt <= vLast ? '0 : vcnt + YBITS'(1);
      end else begin
        hcnt <= hcnt + XBITS'(1);
      end
    end
  end

  // Request stage: fetch strobe, coordinates, frame/line strobes and control bits
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRequest    <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oFrameStart <= 1'b0;
      oLineStart  <= 1'b0;
      reqCtlQ     <= VGA_CTL_IDLE;
    end else if (iEn) begin
      oRequest    <= reqCtl.de;
      oX          <= reqCtl.de ? hcnt : '0;
      oY          <= reqCtl.de ? vcnt : '0;
      oFrameStart <= (hcnt == '0) && (vcnt == '0);
      oLineStart  <= (hcnt == '0) && vActive;
      reqCtlQ     <= reqCtl;
    end
  end

  // Carry control bits across the host fetch latency so they meet their pixel
  vga_delay_line #(
    .WIDTH     ($bits(vga_ctl_t)),
    .DEPTH     (REQ_LEAD),
    .RESET_VAL (VGA_CTL_IDLE)
  ) uCtlDelay (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iEn    (iEn),
    .iData  (reqCtlQ),
    .oData  (dlyCtl)
  );

  // Output stage: gate colour by delayed de and map syncs to their polarity
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_BLANK_N <= 1'b0;
      oVGA_HS      <= ~HS_POL;
      oVGA_VS      <= ~VS_POL;
    end else if (iEn) begin
      oVGA_R       <= dlyCtl.de ? iRed   : '0;
      oVGA_G       <= dlyCtl.de ? iGreen : '0;
      oVGA_B       <= dlyCtl.de ? iBlue  : '0;
      oVGA_BLANK_N <= dlyCtl.de;
      oVGA_HS      <= dlyCtl.hs ? HS_POL : ~HS_POL;
      oVGA_VS      <= dlyCtl.vs ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen across four modes
module tb_vga_timing_gen;

  // 0: 640x480 defaults, 1: small mode lead 3 HS active-high,
  // 2: 800x600 both syncs active-high, 3: tiny mode lead 1
  localparam int N = 4;
  localparam int M_HA   [N] = '{640, 20, 800, 12};
  localparam int M_HF   [N] = '{16, 3, 40, 2};
  localparam int M_HS   [N] = '{96, 5, 128, 3};
  localparam int M_HB   [N] = '{48, 4, 88, 3};
  localparam int M_VA   [N] = '{480, 6, 600, 4};
  localparam int M_VF   [N] = '{10, 2, 1, 1};
  localparam int M_VS   [N] = '{2, 2, 4, 2};
  localparam int M_VB   [N] = '{33, 3, 23, 2};
  localparam int M_LEAD [N] = '{2, 3, 2, 1};
  localparam bit M_HPOL [N] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit M_VPOL [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lead;
    bit hpol, vpol;
  } mode_t;

  typedef struct packed {
    logic        req;
    logic [15:0] x;
    logic [15:0] y;
    logic        fs;
    logic        ls;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        blankN;
  } obs_t;

  logic       iCLK   = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iEn    = 1'b0;
  logic [7:0] hostR [N];
  logic [7:0] hostG [N];
  logic [7:0] hostB [N];
  obs_t       obs   [N];
  int         t       = 0;
  int         nChecks = 0;
  int         nFails  = 0;

  always #5 iCLK = ~iCLK;

  for (genvar i = 0; i < N; i++) begin : gDut
    localparam int HT = M_HA[i] + M_HF[i] + M_HS[i] + M_HB[i];
    localparam int VT = M_VA[i] + M_VF[i] + M_VS[i] + M_VB[i];
    localparam int XB = $clog2(HT);
    localparam int YB = $clog2(VT);
    logic          req, fs, ls, hsO, vsO, bl;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [7:0]    r, g, b;

    vga_timing_gen #(
      .H_ACTIVE (M_HA[i]), .H_FP (M_HF[i]), .H_SYNC (M_HS[i]), .H_BP (M_HB[i]),
      .V_ACTIVE (M_VA[i]), .V_FP (M_VF[i]), .V_SYNC (M_VS[i]), .V_BP (M_VB[i]),
      .HS_POL (M_HPOL[i]), .VS_POL (M_VPOL[i]), .COLOR_W (8), .REQ_LEAD (M_LEAD[i])
    ) dut (
      .iCLK (iCLK), .iRST_N (iRST_N), .iEn (iEn),
      .iRed (hostR[i]), .iGreen (hostG[i]), .iBlue (hostB[i]),
      .oRequest (req), .oX (x), .oY (y), .oFrameStart (fs), .oLineStart (ls),
      .oVGA_R (r), .oVGA_G (g), .oVGA_B (b),
      .oVGA_HS (hsO), .oVGA_VS (vsO), .oVGA_BLANK_N (bl)
    );

    assign obs[i] = '{req: req, x: 16'(x), y: 16'(y), fs: fs, ls: ls,
                      r: r, g: g, b: b, hs: hsO, vs: vsO, blankN: bl};
  end

  function automatic mode_t modeOf(input int i);
    mode_t m;
    m.ha = M_HA[i]; m.hf = M_HF[i]; m.hs = M_HS[i]; m.hb = M_HB[i];
    m.va = M_VA[i]; m.vf = M_VF[i]; m.vs = M_VS[i]; m.vb = M_VB[i];
    m.lead = M_LEAD[i]; m.hpol = M_HPOL[i]; m.vpol = M_VPOL[i];
    return m;
  endfunction

  // Pixel the host returns for coordinate (x,y)
  function automatic logic [23:0] pixel(input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    return {xb, yb, 8'hA5};
  endfunction

  // Expected outputs after enabled tick tk since reset release (tk=0: reset state).
  // Tick tk requests raster position tk-1; the pins show position tk-lead-2.
  function automatic obs_t modelAt(input mode_t m, input int tk);
    obs_t e;
    int ht, vt, p, h, v, q, qh, qv;
    bit de, hs, vs;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    e = '0;
    e.hs = !m.hpol;
    e.vs = !m.vpol;
    if (tk <= 0) return e;
    p = tk - 1;
    h = p % ht;
    v = (p / ht) % vt;
    e.req = (h < m.ha) && (v < m.va);
    if (e.req) begin
      e.x = 16'(h);
      e.y = 16'(v);
    end
    e.fs = (h == 0) && (v == 0);
    e.ls = (h == 0) && (v < m.va);
    q = tk - m.lead - 2;
    if (q >= 0) begin
      qh = q % ht;
      qv = (q / ht) % vt;
      de = (qh < m.ha) && (qv < m.va);
      hs = (qh >= m.ha + m.hf) && (qh < m.ha + m.hf + m.hs);
      vs = (qv >= m.va + m.vf) && (qv < m.va + m.vf + m.vs);
      e.blankN = de;
      if (de) {e.r, e.g, e.b} = pixel(qh, qv);
      e.hs = hs ? m.hpol : !m.hpol;
      e.vs = vs ? m.vpol : !m.vpol;
    end
    return e;
  endfunction

  // Host data presented for enabled edge tn: the pixel requested lead ticks earlier, else noise
  function automatic logic [23:0] hostData(input mode_t m, input int tn, input bit en);
    logic [23:0] d;
    int ht, vt, q, qh, qv;
    d = 24'($urandom);
    if (!en) return d;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    q = tn - m.lead - 2;
    if (q >= 0) begin
      qh = q % ht;
      qv = (q / ht) % vt;
      if (qh < m.ha && qv < m.va) d = pixel(qh, qv);
    end
    return d;
  endfunction

  task automatic step(input bit en);
    int tn;
    iEn = en;
    tn = en ? t + 1 : t;
    for (int i = 0; i < N; i++) begin
      {hostR[i], hostG[i], hostB[i]} = hostData(modeOf(i), tn, en);
    end
    @(posedge iCLK);
    #1;
    if (en) t++;
  endtask

  task automatic applyReset();
    #3 iRST_N = 1'b0;
    iEn = 1'b0;
    repeat (2) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    t = 0;
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    iEn = 1'b1;
    t = 0;
    repeat (2) @(posedge iCLK);
    #1;
    for (int i = 0; i < N; i++) begin
      obs_t e;
      e = modelAt(modeOf(i), 0);
      nChecks++;
      if (obs[i] !== e) begin
        nFails++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", i, obs[i], e);
      end
    end
    nChecks++;
    if (obs[0].hs !== 1'b1 || obs[0].vs !== 1'b1) begin
      nFails++;
      $display("FAIL reset_sync_idle got hs=%b vs=%b exp hs=1 vs=1", obs[0].hs, obs[0].vs);
    end
    iRST_N = 1'b1;
    repeat (300) begin
      step(1'b1);
      for (int i = 0; i < N; i++) begin
        obs_t e;
        e = modelAt(modeOf(i), t);
        nChecks++;
        if (obs[i] !== e) begin
          nFails++;
          if (nFails <= 40) $display("FAIL pre_reset_run dut%0d t=%0d got=%h exp=%h", i, t, obs[i], e);
        end
      end
    end
    #3 iRST_N = 1'b0;
    #1 t = 0;
    for (int i = 0; i < N; i++) begin
      obs_t e;
      e = modelAt(modeOf(i), 0);
      nChecks++;
      if (obs[i] !== e) begin
        nFails++;
        $display("FAIL async_reset_midline dut%0d got=%h exp=%h", i, obs[i], e);
      end
    end
    @(posedge iCLK);
    #1 iRST_N = 1'b1;
    step(1'b1);
    nChecks++;
    if (obs[0].fs !== 1'b1 || obs[0].req !== 1'b1 || obs[0].x !== 16'd0 || obs[0].y !== 16'd0) begin
      nFails++;
      $display("FAIL first_frame_start got fs=%b req=%b x=%0d y=%0d exp fs=1 req=1 x=0 y=0",
               obs[0].fs, obs[0].req, obs[0].x, obs[0].y);
    end
  endtask

  task automatic test_line_timing();
    int reqCnt = 0, hsLow = 0, firstBlank = -1, firstHsLow = -1;
    int lsTimes[$];
    applyReset();
    repeat (2400) begin
      step(1'b1);
      for (int i = 0; i < N; i++) begin
        obs_t e;
        e = modelAt(modeOf(i), t);
        nChecks++;
        if (obs[i] !== e) begin
          nFails++;
          if (nFails <= 40) $display("FAIL line_timing dut%0d t=%0d got=%h exp=%h", i, t, obs[i], e);
        end
      end
      if (obs[0].req === 1'b1) reqCnt++;
      if (obs[0].hs === 1'b0) begin
        hsLow++;
        if (firstHsLow < 0) firstHsLow = t;
      end
      if (obs[0].blankN === 1'b1 && firstBlank < 0) firstBlank = t;
      if (obs[0].ls === 1'b1) lsTimes.push_back(t);
    end
    nChecks++;
    if (reqCnt != 3 * 640) begin
      nFails++;
      $display("FAIL request_ticks_3_lines got=%0d exp=%0d", reqCnt, 3 * 640);
    end
    nChecks++;
    if (hsLow != 3 * 96) begin
      nFails++;
      $display("FAIL hs_low_ticks got=%0d exp=%0d", hsLow, 3 * 96);
    end
    nChecks++;
    if (firstHsLow - firstBlank != 656) begin
      nFails++;
      $display("FAIL hs_offset got=%0d exp=656", firstHsLow - firstBlank);
    end
    nChecks++;
    if (firstBlank != 4) begin
      nFails++;
      $display("FAIL blank_rise_latency got=%0d exp=4", firstBlank);
    end
    nChecks++;
    if (lsTimes.size() != 3 || lsTimes[1] - lsTimes[0] != 800) begin
      nFails++;
      $display("FAIL line_period got count=%0d exp count=3 period 800", lsTimes.size());
    end
  endtask

  task automatic test_full_frame();
    mode_t m;
    int ht, vt, frame, fsCnt = 0, lsCnt = 0, reqCnt = 0, vsAct = 0;
    m = modeOf(1);
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    frame = ht * vt;
    applyReset();
    repeat (2 * frame) begin
      step(1'b1);
      for (int i = 0; i < N; i++) begin
        obs_t e;
        e = modelAt(modeOf(i), t);
        nChecks++;
        if (obs[i] !== e) begin
          nFails++;
          if (nFails <= 40) $display("FAIL full_frame dut%0d t=%0d got=%h exp=%h", i, t, obs[i], e);
        end
      end
      if (obs[1].fs === 1'b1) fsCnt++;
      if (obs[1].ls === 1'b1) lsCnt++;
      if (obs[1].req === 1'b1) reqCnt++;
      if (obs[1].vs === m.vpol) vsAct++;
      if (t == frame) begin
        nChecks++;
        if (obs[1].fs !== 1'b0 || obs[1].req !== 1'b0) begin
          nFails++;
          $display("FAIL wrap_last_tick got fs=%b req=%b exp fs=0 req=0", obs[1].fs, obs[1].req);
        end
      end
      if (t == frame + 1) begin
        nChecks++;
        if (obs[1].fs !== 1'b1 || obs[1].req !== 1'b1 || obs[1].x !== 16'd0 || obs[1].y !== 16'd0) begin
          nFails++;
          $display("FAIL wrap_frame_start got fs=%b req=%b x=%0d y=%0d exp 1 1 0 0",
                   obs[1].fs, obs[1].req, obs[1].x, obs[1].y);
        end
      end
    end
    nChecks++;
    if (fsCnt != 2) begin
      nFails++;
      $display("FAIL frame_starts got=%0d exp=2", fsCnt);
    end
    nChecks++;
    if (lsCnt != 2 * m.va) begin
      nFails++;
      $display("FAIL line_starts got=%0d exp=%0d", lsCnt, 2 * m.va);
    end
    nChecks++;
    if (reqCnt != 2 * m.ha * m.va) begin
      nFails++;
      $display("FAIL frame_requests got=%0d exp=%0d", reqCnt, 2 * m.ha * m.va);
    end
    nChecks++;
    if (vsAct != 2 * m.vs * ht) begin
      nFails++;
      $display("FAIL vs_width got=%0d exp=%0d", vsAct, 2 * m.vs * ht);
    end
  endtask

  task automatic test_latency();
    applyReset();
    repeat (600) begin
      step(1'b1);
      for (int i = 0; i < N; i++) begin
        obs_t e;
        e = modelAt(modeOf(i), t);
        nChecks++;
        if (obs[i] !== e) begin
          nFails++;
          if (nFails <= 40) $display("FAIL latency dut%0d t=%0d got=%h exp=%h", i, t, obs[i], e);
        end
        if (obs[i].blankN === 1'b0) begin
          nChecks++;
          if ({obs[i].r, obs[i].g, obs[i].b} !== 24'h0) begin
            nFails++;
            if (nFails <= 40) $display("FAIL rgb_in_blank dut%0d t=%0d got=%h exp=0", i, t,
                                       {obs[i].r, obs[i].g, obs[i].b});
          end
        end
        if (t == M_LEAD[i] + 1 || t == M_LEAD[i] + 2) begin
          nChecks++;
          if (obs[i].blankN !== (t == M_LEAD[i] + 2)) begin
            nFails++;
            $display("FAIL first_blank_edge dut%0d t=%0d got=%b exp=%b", i, t, obs[i].blankN,
                     t == M_LEAD[i] + 2);
          end
        end
      end
    end
  endtask

  task automatic test_polarity();
    int hsAct = 0, vsAct = 0, firstBlank = -1, firstHs = -1;
    applyReset();
    repeat (2 * 1056) begin
      step(1'b1);
      for (int i = 0; i < N; i++) begin
        obs_t e;
        e = modelAt(modeOf(i), t);
        nChecks++;
        if (obs[i] !== e) begin
          nFails++;
          if (nFails <= 40) $display("FAIL polarity dut%0d t=%0d got=%h exp=%h", i, t, obs[i], e);
        end
      end
      if (obs[2].hs === 1'b1) begin
        hsAct++;
        if (firstHs < 0) firstHs = t;
      end
      if (obs[2].vs === 1'b1) vsAct++;
      if (obs[2].blankN === 1'b1 && firstBlank < 0) firstBlank = t;
    end
    nChecks++;
    if (hsAct != 2 * 128) begin
      nFails++;
      $display("FAIL svga_hs_high_ticks got=%0d exp=%0d", hsAct, 2 * 128);
    end
    nChecks++;
    if (vsAct != 0) begin
      nFails++;
      $display("FAIL svga_vs_idle_low got=%0d high ticks exp=0", vsAct);
    end
    nChecks++;
    if (firstHs - firstBlank != 840) begin
      nFails++;
      $display("FAIL svga_hs_offset got=%0d exp=840", firstHs - firstBlank);
    end
  endtask

  task automatic test_enable_pattern(input bit randomEn, input int cycles);
    applyReset();
    for (int c = 0; c < cycles; c++) begin
      step(randomEn ? ($urandom_range(0, 2) != 0) : c[0]);
      for (int i = 0; i < N; i++) begin
        obs_t e;
        e = modelAt(modeOf(i), t);
        nChecks++;
        if (obs[i] !== e) begin
          nFails++;
          if (nFails <= 40) $display("FAIL enable_%s dut%0d t=%0d got=%h exp=%h",
                                     randomEn ? "random" : "half", i, t, obs[i], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    repeat (3) begin
      int n;
      n = $urandom_range(40, 1200);
      repeat (n) begin
        step($urandom_range(0, 3) != 0);
        for (int i = 0; i < N; i++) begin
          obs_t e;
          e = modelAt(modeOf(i), t);
          nChecks++;
          if (obs[i] !== e) begin
            nFails++;
            if (nFails <= 40) $display("FAIL b2b_run dut%0d t=%0d got=%h exp=%h", i, t, obs[i], e);
          end
        end
      end
      #3 iRST_N = 1'b0;
      #1 t = 0;
      for (int i = 0; i < N; i++) begin
        obs_t e;
        e = modelAt(modeOf(i), 0);
        nChecks++;
        if (obs[i] !== e) begin
          nFails++;
          $display("FAIL midframe_reset dut%0d got=%h exp=%h", i, obs[i], e);
        end
      end
      @(posedge iCLK);
      #1 iRST_N = 1'b1;
      step(1'b1);
      nChecks++;
      if (obs[1].fs !== 1'b1 || obs[1].req !== 1'b1 || obs[1].x !== 16'd0 || obs[1].y !== 16'd0) begin
        nFails++;
        $display("FAIL restart_origin got fs=%b req=%b x=%0d y=%0d exp 1 1 0 0",
                 obs[1].fs, obs[1].req, obs[1].x, obs[1].y);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      hostR[i] = 8'h0;
      hostG[i] = 8'h0;
      hostB[i] = 8'h0;
    end
    test_reset();
    test_line_timing();
    test_full_frame();
    test_latency();
    test_polarity();
    test_enable_pattern(1'b0, 2000);
    test_enable_pattern(1'b1, 3000);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
